// File: rtl/alu_seq.sv
// ---------------------------------------------------------------------------
// alu_seq -- registered WIDTH-bit ALU with a valid/ready input handshake.
//
// Single-cycle ops (ADD/SUB/logic/shifts/ADC/SBC/reserved) are evaluated
// combinationally and registered on the accept edge. MUL runs as an
// iterative shift-add over WIDTH cycles while in_ready is held low.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands/opcode valid
//   in_ready   unit can accept a new operation (high only when idle)
//   a, b       operands (b also supplies the shift amount in its low SHW bits)
//   ci         carry in, used by ADC/SBC only
//   selec_alu  4-bit opcode
//   result     registered result, holds between completions
//   out_valid  one-cycle pulse when result/flags have been updated
//   f_N/f_Z/f_C/f_V  registered negative/zero/carry/overflow flags
// ---------------------------------------------------------------------------
module alu_seq #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic [3:0]       selec_alu,
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             f_N,
    output logic             f_Z,
    output logic             f_C,
    output logic             f_V
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_MUL  = 1'b1;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SHL = 4'b0101;
    localparam logic [3:0] OP_SHR = 4'b0110;
    localparam logic [3:0] OP_ASR = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;
    localparam logic [3:0] OP_ADC = 4'b1001;
    localparam logic [3:0] OP_SBC = 4'b1010;

    localparam int            CW       = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [0:0]         state_reg;
    logic [WIDTH-1:0]   result_reg;
    logic               out_valid_reg;
    logic               n_reg, z_reg, c_reg, v_reg;
    logic [2*WIDTH-1:0] mcand_reg;   // multiplicand, shifted left each step
    logic [WIDTH-1:0]   mplier_reg;  // multiplier, shifted right each step
    logic [2*WIDTH-1:0] acc_reg;     // partial product
    logic [CW-1:0]      cnt_reg;

    // ------------------------------------------------------------------
    // Single-cycle datapath
    // ------------------------------------------------------------------
    logic               is_sub;
    logic [WIDTH-1:0]   addend;
    logic               carry_in;
    logic [WIDTH:0]     sum_next;
    logic [SHW-1:0]     shamt;
    logic [WIDTH:0]     shl_ext;
    logic [WIDTH:0]     shr_ext;
    logic signed [WIDTH:0] asr_ext;
    logic [WIDTH-1:0]   res_next;
    logic               c_next, v_next;
    logic               n_next, z_next;

    // Subtraction is a + ~b + cin: cin=1 gives a-b, cin=ci gives a-b-!ci.
    // The carry out of that sum is then directly "not borrow".
    assign is_sub   = (selec_alu == OP_SUB) || (selec_alu == OP_SBC);
    assign addend   = is_sub ? ~b : b;
    assign carry_in = (selec_alu == OP_SUB) ? 1'b1 :
                      ((selec_alu == OP_ADC) || (selec_alu == OP_SBC)) ? ci : 1'b0;
    assign sum_next = {1'b0, a} + {1'b0, addend} + {{WIDTH{1'b0}}, carry_in};

    // Shifts are done one bit wider so the last bit shifted out lands in
    // the extra position; a zero amount leaves that bit at 0.
    assign shamt   = b[SHW-1:0];
    assign shl_ext = {1'b0, a} << shamt;
    assign shr_ext = {a, 1'b0} >> shamt;
    assign asr_ext = $signed({a, 1'b0}) >>> shamt;

    always_comb begin
        res_next = '0;
        c_next   = 1'b0;
        v_next   = 1'b0;
        case (selec_alu)
            OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                res_next = sum_next[WIDTH-1:0];
                c_next   = sum_next[WIDTH];
                // Equal-sign addends (b already inverted for subtraction)
                // producing a result of the other sign.
                v_next   = (a[WIDTH-1] == addend[WIDTH-1]) &&
                           (sum_next[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: res_next = a & b;
            OP_OR:  res_next = a | b;
            OP_XOR: res_next = a ^ b;
            OP_SHL: begin
                res_next = shl_ext[WIDTH-1:0];
                c_next   = shl_ext[WIDTH];
            end
            OP_SHR: begin
                res_next = shr_ext[WIDTH:1];
                c_next   = shr_ext[0];
            end
            OP_ASR: begin
                res_next = asr_ext[WIDTH:1];
                c_next   = asr_ext[0];
            end
            default: begin
                // MUL completes in the sequencer; reserved opcodes give 0.
                res_next = '0;
            end
        endcase
    end

    assign n_next = res_next[WIDTH-1];
    assign z_next = (res_next == '0);

    // ------------------------------------------------------------------
    // Multiply step
    // ------------------------------------------------------------------
    logic [2*WIDTH-1:0] acc_step;
    assign acc_step = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;

    // ------------------------------------------------------------------
    // Control and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            result_reg    <= '0;
            out_valid_reg <= 1'b0;
            n_reg         <= 1'b0;
            z_reg         <= 1'b0;
            c_reg         <= 1'b0;
            v_reg         <= 1'b0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
        end else begin
            out_valid_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (in_valid) begin
                        if (selec_alu == OP_MUL) begin
                            state_reg  <= ST_MUL;
                            cnt_reg    <= '0;
                            acc_reg    <= '0;
                            mcand_reg  <= {{WIDTH{1'b0}}, a};
                            mplier_reg <= b;
                        end else begin
                            result_reg    <= res_next;
                            n_reg         <= n_next;
                            z_reg         <= z_next;
                            c_reg         <= c_next;
                            v_reg         <= v_next;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                ST_MUL: begin
                    acc_reg    <= acc_step;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg + 1'b1;
                    if (cnt_reg == CNT_LAST) begin
                        // Final step: the full product is acc_step.
                        result_reg    <= acc_step[WIDTH-1:0];
                        n_reg         <= acc_step[WIDTH-1];
                        z_reg         <= (acc_step[WIDTH-1:0] == '0);
                        c_reg         <= |acc_step[2*WIDTH-1:WIDTH];
                        v_reg         <= 1'b0;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == ST_IDLE);
    assign result    = result_reg;
    assign out_valid = out_valid_reg;
    assign f_N       = n_reg;
    assign f_Z       = z_reg;
    assign f_C       = c_reg;
    assign f_V       = v_reg;

endmodule

// File: tb/tb_alu_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_seq -- self-checking bench for alu_seq (WIDTH=8).
// Directed vector table, hand-written multi-cycle sequences (back-to-back,
// busy multiply, reset during multiply) and random ops against an
// integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_alu_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic [3:0]   selec_alu = 4'h0;
    logic [W-1:0] result;
    logic         out_valid;
    logic         f_N, f_Z, f_C, f_V;

    int n_vec = 0;
    int n_cmp = 0;
    int n_err = 0;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .selec_alu (selec_alu),
        .result    (result),
        .out_valid (out_valid),
        .f_N       (f_N),
        .f_Z       (f_Z),
        .f_C       (f_C),
        .f_V       (f_V)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0] res;
        logic [3:0]   nzcv;
    } exp_t;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         ci;
        logic [W-1:0] res;
        logic [3:0]   nzcv;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp_v);
        end
    endtask

    function automatic logic out_of_range(input int s);
        return (s > 127) || (s < -128);
    endfunction

    // Reference model: plain integer arithmetic on the operation definitions.
    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] av,
                                   input logic [W-1:0] bv, input logic civ);
        int ua, ub, sa, sb, full, amt, r, cin;
        logic c, v;
        logic [W-1:0] res;
        exp_t e;
        ua  = int'(av);
        ub  = int'(bv);
        sa  = int'($signed(av));
        sb  = int'($signed(bv));
        cin = civ ? 1 : 0;
        amt = ub % W;
        c = 1'b0; v = 1'b0; r = 0; full = 0;
        case (op)
            4'h0: begin full = ua + ub; r = full; c = full > 255; v = out_of_range(sa + sb); end
            4'h1: begin full = ua - ub; r = full; c = ua >= ub;  v = out_of_range(sa - sb); end
            4'h2: r = ua & ub;
            4'h3: r = ua | ub;
            4'h4: r = ua ^ ub;
            4'h5: begin
                r = ua << amt;
                c = (amt != 0) && (((ua >> (W - amt)) & 1) == 1);
            end
            4'h6: begin
                r = ua >> amt;
                c = (amt != 0) && (((ua >> (amt - 1)) & 1) == 1);
            end
            4'h7: begin
                r = sa >>> amt;
                c = (amt != 0) && (((ua >> (amt - 1)) & 1) == 1);
            end
            4'h8: begin full = ua * ub; r = full; c = full > 255; end
            4'h9: begin full = ua + ub + cin; r = full; c = full > 255; v = out_of_range(sa + sb + cin); end
            4'hA: begin full = ua - ub - (1 - cin); r = full; c = full >= 0; v = out_of_range(sa - sb - (1 - cin)); end
            default: r = 0;
        endcase
        res    = r[W-1:0];
        e.res  = res;
        e.nzcv = {res[W-1], (res == '0), c, v};
        return e;
    endfunction

    // Apply one op through the handshake and check result, flags, latency
    // and that out_valid is a single-cycle pulse.
    task automatic run_op(input logic [3:0] op, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic civ, input logic [W-1:0] exp_res, input logic [3:0] exp_nzcv);
        int wait_cyc;
        int lat;
        int exp_lat;
        wait_cyc = 0;
        @(negedge clk);
        while (!in_ready && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        check("in_ready_before_op", 32'(in_ready), 32'd1);
        selec_alu = op; a = av; b = bv; ci = civ; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        exp_lat = (op == 4'h8) ? W + 1 : 1;
        n_vec++;
        $display("vec %0d op=%h a=%h b=%h ci=%b -> result=%h nzcv=%b%b%b%b lat=%0d (exp %h %b)",
                 n_vec, op, av, bv, civ, result, f_N, f_Z, f_C, f_V, lat, exp_res, exp_nzcv);
        check("latency", 32'(lat), 32'(exp_lat));
        check("result", 32'(result), 32'(exp_res));
        check("nzcv", 32'({f_N, f_Z, f_C, f_V}), 32'(exp_nzcv));
        @(negedge clk);
        check("out_valid_single_pulse", 32'(out_valid), 32'd0);
    endtask

    vec_t vt[18];

    initial begin
        exp_t e;
        int pulses;
        logic [3:0]   rop;
        logic [W-1:0] ra, rb;
        logic         rci;

        //          op     a      b      ci    res    nzcv
        vt[0]  = '{4'h0, 8'h03, 8'h01, 1'b0, 8'h04, 4'b0000};
        vt[1]  = '{4'h0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1001};
        vt[2]  = '{4'h1, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b1000};
        vt[3]  = '{4'hA, 8'h05, 8'h02, 1'b0, 8'h02, 4'b0010};
        vt[4]  = '{4'h7, 8'h81, 8'h01, 1'b0, 8'hC0, 4'b1010};
        vt[5]  = '{4'h5, 8'h81, 8'h08, 1'b0, 8'h81, 4'b1000};
        vt[6]  = '{4'hC, 8'h12, 8'h34, 1'b1, 8'h00, 4'b0100};
        vt[7]  = '{4'h2, 8'hF0, 8'h3C, 1'b0, 8'h30, 4'b0000};
        vt[8]  = '{4'h3, 8'h0F, 8'hF0, 1'b0, 8'hFF, 4'b1000};
        vt[9]  = '{4'h4, 8'hAA, 8'hAA, 1'b0, 8'h00, 4'b0100};
        vt[10] = '{4'h6, 8'h81, 8'h03, 1'b0, 8'h10, 4'b0000};
        vt[11] = '{4'h9, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b0110};
        vt[12] = '{4'h1, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b0011};
        vt[13] = '{4'h8, 8'h10, 8'h10, 1'b0, 8'h00, 4'b0110};
        vt[14] = '{4'h8, 8'h0F, 8'h0F, 1'b0, 8'hE1, 4'b1000};
        vt[15] = '{4'h5, 8'h81, 8'h01, 1'b0, 8'h02, 4'b0010};
        vt[16] = '{4'h0, 8'hFF, 8'h01, 1'b0, 8'h00, 4'b0110};
        vt[17] = '{4'hA, 8'h05, 8'h05, 1'b1, 8'h00, 4'b0110};

        // Reset state
        #2;
        check("reset_result", 32'(result), 32'd0);
        check("reset_flags", 32'({f_N, f_Z, f_C, f_V}), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table
        for (int i = 0; i < 18; i++)
            run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].ci, vt[i].res, vt[i].nzcv);

        // Back-to-back ADDs: out_valid high on two consecutive cycles
        @(negedge clk);
        selec_alu = 4'h0; a = 8'h03; b = 8'h01; ci = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        a = 8'h7F; b = 8'h01;
        n_vec++;
        $display("b2b first: out_valid=%b result=%h nzcv=%b%b%b%b", out_valid, result, f_N, f_Z, f_C, f_V);
        check("b2b1_out_valid", 32'(out_valid), 32'd1);
        check("b2b1_result", 32'(result), 32'h04);
        check("b2b1_nzcv", 32'({f_N, f_Z, f_C, f_V}), 32'b0000);
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        $display("b2b second: out_valid=%b result=%h nzcv=%b%b%b%b", out_valid, result, f_N, f_Z, f_C, f_V);
        check("b2b2_out_valid", 32'(out_valid), 32'd1);
        check("b2b2_result", 32'(result), 32'h80);
        check("b2b2_nzcv", 32'({f_N, f_Z, f_C, f_V}), 32'b1001);
        @(negedge clk);
        check("b2b_out_valid_low", 32'(out_valid), 32'd0);
        check("b2b_result_held", 32'(result), 32'h80);

        // MUL busy window with a competing in_valid that must be ignored
        @(negedge clk);
        selec_alu = 4'h8; a = 8'h10; b = 8'h10; in_valid = 1'b1;
        for (int k = 1; k <= W; k++) begin
            @(negedge clk);
            check("mul_busy_in_ready", 32'(in_ready), 32'd0);
            check("mul_busy_out_valid", 32'(out_valid), 32'd0);
            if (k == 1) begin
                selec_alu = 4'h0; a = 8'h01; b = 8'h01;
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
        n_vec++;
        $display("mul busy: out_valid=%b in_ready=%b result=%h nzcv=%b%b%b%b", out_valid, in_ready,
                 result, f_N, f_Z, f_C, f_V);
        check("mul_done_out_valid", 32'(out_valid), 32'd1);
        check("mul_done_in_ready", 32'(in_ready), 32'd1);
        check("mul_done_result", 32'(result), 32'h00);
        check("mul_done_nzcv", 32'({f_N, f_Z, f_C, f_V}), 32'b0110);
        @(negedge clk);
        check("mul_done_single_pulse", 32'(out_valid), 32'd0);
        check("mul_done_result_held", 32'(result), 32'h00);

        // Reset three cycles into a multiply
        run_op(4'h0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b1001);
        @(negedge clk);
        selec_alu = 4'h8; a = 8'h0F; b = 8'h0F; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        $display("reset mid-mul: result=%h nzcv=%b%b%b%b in_ready=%b out_valid=%b", result,
                 f_N, f_Z, f_C, f_V, in_ready, out_valid);
        check("rst_mul_result", 32'(result), 32'd0);
        check("rst_mul_flags", 32'({f_N, f_Z, f_C, f_V}), 32'd0);
        check("rst_mul_in_ready", 32'(in_ready), 32'd1);
        check("rst_mul_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        pulses = 0;
        for (int k = 0; k < 2 * W; k++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("rst_mul_no_pulse", 32'(pulses), 32'd0);
        check("rst_mul_idle", 32'(in_ready), 32'd1);

        // Random ops against the reference model
        for (int i = 0; i < 200; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rci = 1'($urandom);
            e   = model(rop, ra, rb, rci);
            run_op(rop, ra, rb, rci, e.res, e.nzcv);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the 4-bit combinational ALU: WIDTH-bit datapath, extended opcode set, valid/ready input handshake and registered result/flag outputs.
- Multiply runs as an iterative shift-add sequence; all other ops complete in one cycle.
- Sits between the register-file read stage and write-back in the single-cycle processor datapath, and is reusable as a standalone execution unit.

Parameters:
- WIDTH, 8, operand/result width in bits (≥2, power of two).
- SHW, $clog2(WIDTH), number of low bits of b used as the shift amount.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands/opcode valid
- in_ready  output  1  unit can accept a new operation
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B / shift amount
- ci  input  1  carry in (ADC/SBC only)
- selec_alu  input  4  opcode
- result  output  WIDTH  registered result
- out_valid  output  1  one-cycle pulse: result/flags updated
- f_N, f_Z, f_C, f_V  output  1 each  registered negative/zero/carry/overflow flags

Behaviour:
- Reset (async, rst_n=0): result=0, all flags=0, out_valid=0, state=IDLE, in_ready=1, multiply registers cleared. Reset during a multiply aborts it and produces no out_valid.
- Accept: an operation is accepted on a clk edge where in_valid && in_ready. in_ready is 1 exactly when state==IDLE.
- Opcodes:
  - 0000 ADD
  - 0001 SUB (a-b)
  - 0010 AND
  - 0011 OR
  - 0100 XOR
  - 0101 SHL
  - 0110 SHR (logical)
  - 0111 ASR
  - 1000 MUL (low WIDTH bits)
  - 1001 ADC (a+b+ci)
  - 1010 SBC (a-b-!ci)
  - 1011–1111 reserved: result=0, Z=1, N=C=V=0.
- Single-cycle ops: result/flags registered on the accept edge; out_valid=1 in the following cycle. Back-to-back accepts every cycle are allowed.
- MUL state machine: IDLE -> MUL on accept; counter=0, accumulator=0, latched multiplicand/multiplier. Each MUL cycle adds the shifted multiplicand when the current multiplier bit is 1 and increments the counter. After WIDTH iterations it writes result/flags, sets out_valid, and returns to IDLE. out_valid rises WIDTH+1 cycles after the accept edge; in_ready=0 for the WIDTH cycles between them. in_valid is ignored while busy.
- Arithmetic: internal sums are WIDTH+1 bits.
  - C = carry out for ADD/ADC.
  - C = NOT borrow for SUB/SBC (1 when no borrow).
  - V = signed overflow: operands of equal sign (ADD) or opposite sign (SUB) yielding a result of different sign.
- Logic ops: C=0, V=0.
- Shifts: amount = b[SHW-1:0]. C = last bit shifted out; amount 0 gives unchanged a and C=0. V=0. ASR replicates the MSB.
- MUL: full 2*WIDTH product computed. C=1 iff upper WIDTH bits are nonzero. V=0.
- All ops: N = result[WIDTH-1]; Z = (result==0).
- result and flags hold their last values between completions. out_valid is never high for two cycles from one accept.

Test Plan:
1. Reset mid-MUL: rst_n=0 for 1 cycle, 3 cycles after a MUL accept -> immediate result=0, flags=0, in_ready=1; no out_valid pulse follows.
2. WIDTH=8, ADD a=0x03 b=0x01, then ADD a=0x7F b=0x01 on consecutive cycles:
   - first result 0x04, NZCV=0000;
   - second result 0x80, N=1 V=1 C=0;
   - out_valid high two consecutive cycles.
3. SUB a=0x00 b=0x01 -> result 0xFF, N=1 Z=0 C=0 V=0. SBC a=0x05 b=0x02 ci=0 -> result 0x02, C=1.
4. MUL a=0x10 b=0x10 -> in_ready=0 for 8 cycles; out_valid exactly 9 cycles after accept; result 0x00, Z=1, C=1. A concurrent in_valid during busy is not accepted.
5. ASR a=0x81 b=0x01 -> result 0xC0, N=1, C=1. SHL a=0x81 b=0x08 (amount 0) -> result 0x81, C=0.
6. Reserved opcode 1100 -> result 0x00, Z=1, N=C=V=0; out_valid pulses once.
